test_obi_master: RTL and testbench
==================================

TEST_OBI_MASTER -- requirements
Module: test_obi_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles spent in REQ plus RESP before abort; 0 disables timeout.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 addr_i  input  32  transaction address from test CSR.
REQ-005 wdata_i  input  32  write data from test CSR.
REQ-006 start_read_i  input  1  one-cycle pulse, start read.
REQ-007 start_write_i  input  1  one-cycle pulse, start write.
REQ-008 rdata_o  output  32  data of last successful read, fed back to CSR.
REQ-009 busy_o  output  1  high while state is not IDLE.
REQ-010 done_o  output  1  one-cycle pulse on every completion (success or error).
REQ-011 err_code_o  output  2  0 none, 1 bus error, 2 timeout, 3 illegal request.
REQ-012 req_o  output  1  OBI request.
REQ-013 gnt_i  input  1  OBI grant.
REQ-014 addr_o  output  32  OBI address.
REQ-015 we_o  output  1  OBI write enable.
REQ-016 be_o  output  4  OBI byte enables.
REQ-017 wdata_o  output  32  OBI write data.
REQ-018 rvalid_i  input  1  OBI response valid.
REQ-019 rdata_i  input  32  OBI read data.
REQ-020 err_i  input  1  OBI response error, sampled with rvalid_i.

Function
REQ-021 FSM states SHALL be IDLE, REQ, RESP.
REQ-022 In IDLE, exactly one start pulse with addr_i[1:0]==0 SHALL latch addr_i, wdata_i, we (1 for write) and enter REQ next cycle; err_code_o cleared to 0 same edge.
REQ-023 In IDLE, both start pulses high, or addr_i[1:0]!=0, SHALL issue no bus request, set err_code_o=3, pulse done_o next cycle, stay IDLE.
REQ-024 Start pulses while busy_o=1 SHALL be ignored with no side effects.
REQ-025 In REQ: req_o=1; addr_o, we_o, wdata_o from latched values; be_o=4'hF; all held stable until gnt_i.
REQ-026 REQ with gnt_i=1 SHALL go to RESP; req_o low from next cycle.
REQ-027 In RESP, req_o=0; rvalid_i=1 SHALL return to IDLE and pulse done_o the following cycle.
REQ-028 On rvalid_i with err_i=0 and we=0, rdata_o SHALL load rdata_i; writes and errored reads leave rdata_o unchanged.
REQ-029 On rvalid_i with err_i=1, err_code_o SHALL become 1.
REQ-030 rvalid_i in IDLE or REQ (including late response after timeout) SHALL be ignored.
REQ-031 Timeout counter, width $clog2(TIMEOUT_CYCLES+1), SHALL clear on entry to REQ, increment each cycle in REQ/RESP, saturate.
REQ-032 When counter equals TIMEOUT_CYCLES (nonzero) without completion: go IDLE, err_code_o=2, pulse done_o; req_o drops same edge.
REQ-033 Completion (gnt/rvalid) in the cycle the counter reaches limit SHALL win over timeout.
REQ-034 Minimum transaction latency: start pulse cycle N, req_o at N+1, gnt at N+1, rvalid at N+2, done_o at N+3.
REQ-035 err_code_o SHALL hold until next accepted start or illegal request.

Reset
REQ-036 Asynchronous reset SHALL force IDLE, counter 0, req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, rdata_o=0, done_o=0, busy_o=0, err_code_o=0.
REQ-037 Reset mid-transaction SHALL abandon the transaction with no done_o pulse; responses after reset ignored per REQ-030.

Structure
REQ-038 Package test_obi_pkg SHALL hold state enum and err_code enum (ERR_NONE, ERR_BUS, ERR_TIMEOUT, ERR_ILLEGAL).
REQ-039 No sub-module: FSM, latches and timeout counter in one module.

Verification
REQ-040 Read 0x1000, gnt immediate, rvalid next cycle rdata_i=0xDEADBEEF -> rdata_o=0xDEADBEEF, done_o at N+3, err_code_o=0.
REQ-041 Write 0x2004 data 0x12345678, gnt after 3 cycles -> addr_o/wdata_o stable 4 cycles, we_o=1, be_o=F, rdata_o unchanged.
REQ-042 Read with rvalid_i and err_i=1 -> err_code_o=1, rdata_o unchanged, done_o pulse.
REQ-043 TIMEOUT_CYCLES=8, gnt_i never -> req_o drops after 8 cycles, err_code_o=2; later rvalid ignored.
REQ-044 Both starts high, then read to 0x1002 -> err_code_o=3 each, req_o never asserted.
REQ-045 rst_ni low while in RESP -> all outputs reset values, no done_o, subsequent read succeeds.

Source files
------------

// File: rtl/test_obi_pkg.sv
// Shared types for the OBI test master: FSM state encoding and completion codes.
package test_obi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BUS     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_code_e;

endpackage

// File: rtl/test_obi_master.sv
// Single-transaction OBI master driven by test CSR pulses; reports completion,
// last read data and an error code, with an optional REQ+RESP timeout.
module test_obi_master
  import test_obi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        start_read_i,
  input  logic        start_write_i,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_code_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e      state_q;
  err_code_e   err_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic        timeout_hit;
  logic        req_q, we_q, done_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  // Abort on the edge where the counter reaches the limit; gnt/rvalid are
  // checked first so a completion in that same cycle wins.
  always_comb begin
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_read_i || start_write_i) begin
            if ((start_read_i && start_write_i) || (addr_i[1:0] != 2'b00)) begin
              err_q  <= ERR_ILLEGAL;
              done_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              addr_q  <= addr_i;
              wdata_q <= wdata_i;
              we_q    <= start_write_i;
              be_q    <= 4'hF;
              err_q   <= ERR_NONE;
              cnt_q   <= '0;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_d;
          if (gnt_i) begin
            state_q <= S_RESP;
            req_q   <= 1'b0;
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
          end
        end
        S_RESP: begin
          cnt_q <= cnt_d;
          if (rvalid_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            if (err_i) begin
              err_q <= ERR_BUS;
            end else if (!we_q) begin
              rdata_q <= rdata_i;
            end
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign err_code_o = err_q;
  assign rdata_o    = rdata_q;
  assign req_o      = req_q;
  assign addr_o     = addr_q;
  assign we_o       = we_q;
  assign be_o       = be_q;
  assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_test_obi_master.sv
// Scenario bench for test_obi_master: expected completions are queued at start
// and checked by a done_o monitor; each scenario also checks bus behaviour inline.
module tb_test_obi_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        start_read_i = 1'b0;
  logic        start_write_i = 1'b0;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_code_o;
  logic        req_o;
  logic        gnt_i = 1'b0;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic        err_i = 1'b0;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  test_obi_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .start_read_i (start_read_i),
    .start_write_i(start_write_i),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_code_o   (err_code_o),
    .req_o        (req_o),
    .gnt_i        (gnt_i),
    .addr_o       (addr_o),
    .we_o         (we_o),
    .be_o         (be_o),
    .wdata_o      (wdata_o),
    .rvalid_i     (rvalid_i),
    .rdata_i      (rdata_i),
    .err_i        (err_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (rst_ni && done_o) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done err=%0d rdata=%h required no done", err_code_o, rdata_o);
      end else begin
        e = sb.pop_front();
        if ({err_code_o, rdata_o} !== {e.err, e.rdata}) begin
          bad++;
          $display("FAIL sb_done err=%0d rdata=%h required err=%0d rdata=%h",
                   err_code_o, rdata_o, e.err, e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    tick();
    tick();
    total++;
    if ({req_o, we_o, be_o, addr_o, wdata_o, rdata_o, done_o, busy_o, err_code_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs req=%b we=%b be=%h addr=%h wd=%h rd=%h done=%b busy=%b err=%0d required all zero",
               req_o, we_o, be_o, addr_o, wdata_o, rdata_o, done_o, busy_o, err_code_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_read;
    sb.push_back('{err: 2'd0, rdata: 32'hDEADBEEF});
    start_read_i = 1'b1;
    addr_i = 32'h0000_1000;
    tick();
    start_read_i = 1'b0;
    total++;
    if ({req_o, busy_o, we_o, be_o, addr_o} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_1000}) begin
      bad++;
      $display("FAIL read_req req=%b busy=%b we=%b be=%h addr=%h required 1 1 0 f 00001000",
               req_o, busy_o, we_o, be_o, addr_o);
    end
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    total++;
    if (req_o !== 1'b0) begin
      bad++;
      $display("FAIL read_req_drop req=%b required 0", req_o);
    end
    rvalid_i = 1'b1;
    rdata_i = 32'hDEADBEEF;
    tick();
    rvalid_i = 1'b0;
    total++;
    if ({done_o, busy_o, err_code_o, rdata_o} !== {1'b1, 1'b0, 2'd0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL read_done_n3 done=%b busy=%b err=%0d rdata=%h required 1 0 0 deadbeef",
               done_o, busy_o, err_code_o, rdata_o);
    end
    tick();
  endtask

  task automatic test_write;
    sb.push_back('{err: 2'd0, rdata: 32'hDEADBEEF});
    start_write_i = 1'b1;
    addr_i = 32'h0000_2004;
    wdata_i = 32'h1234_5678;
    tick();
    start_write_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // a start pulse while busy must not disturb the latched request
      start_read_i = (i == 1);
      addr_i = (i == 1) ? 32'h7770_0000 : 32'h0000_2004;
      total++;
      if ({req_o, we_o, be_o, addr_o, wdata_o} !== {1'b1, 1'b1, 4'hF, 32'h0000_2004, 32'h1234_5678}) begin
        bad++;
        $display("FAIL write_hold[%0d] req=%b we=%b be=%h addr=%h wd=%h required 1 1 f 00002004 12345678",
                 i, req_o, we_o, be_o, addr_o, wdata_o);
      end
      gnt_i = (i == 3);
      tick();
    end
    start_read_i = 1'b0;
    gnt_i = 1'b0;
    rvalid_i = 1'b1;
    rdata_i = 32'hAAAA_5555;
    tick();
    rvalid_i = 1'b0;
    total++;
    if ({done_o, err_code_o, rdata_o} !== {1'b1, 2'd0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL write_done done=%b err=%0d rdata=%h required 1 0 deadbeef",
               done_o, err_code_o, rdata_o);
    end
    tick();
    total++;
    if ({busy_o, req_o, done_o} !== 3'b000) begin
      bad++;
      $display("FAIL write_busy_ignored busy=%b req=%b done=%b required 000", busy_o, req_o, done_o);
    end
  endtask

  task automatic test_bus_err;
    sb.push_back('{err: 2'd1, rdata: 32'hDEADBEEF});
    start_read_i = 1'b1;
    addr_i = 32'h0000_3000;
    tick();
    start_read_i = 1'b0;
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    rvalid_i = 1'b1;
    err_i = 1'b1;
    rdata_i = 32'h1111_1111;
    tick();
    rvalid_i = 1'b0;
    err_i = 1'b0;
    total++;
    if ({done_o, err_code_o, rdata_o} !== {1'b1, 2'd1, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL bus_err done=%b err=%0d rdata=%h required 1 1 deadbeef",
               done_o, err_code_o, rdata_o);
    end
    tick();
  endtask

  task automatic test_limit;
    sb.push_back('{err: 2'd0, rdata: 32'h0BAD_CAFE});
    start_read_i = 1'b1;
    addr_i = 32'h0000_4000;
    tick();
    start_read_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (req_o !== 1'b1) begin
        bad++;
        $display("FAIL limit_req[%0d] req=%b required 1", i, req_o);
      end
      gnt_i = (i == 7);
      tick();
    end
    gnt_i = 1'b0;
    total++;
    if ({req_o, busy_o} !== 2'b01) begin
      bad++;
      $display("FAIL limit_gnt_wins req=%b busy=%b required 0 1", req_o, busy_o);
    end
    rvalid_i = 1'b1;
    rdata_i = 32'h0BAD_CAFE;
    tick();
    rvalid_i = 1'b0;
    total++;
    if ({done_o, err_code_o, rdata_o} !== {1'b1, 2'd0, 32'h0BAD_CAFE}) begin
      bad++;
      $display("FAIL limit_done done=%b err=%0d rdata=%h required 1 0 0badcafe",
               done_o, err_code_o, rdata_o);
    end
    tick();
  endtask

  task automatic test_timeout;
    int n;
    sb.push_back('{err: 2'd2, rdata: 32'h0BAD_CAFE});
    start_read_i = 1'b1;
    addr_i = 32'h0000_5000;
    tick();
    start_read_i = 1'b0;
    n = 0;
    while (req_o && n < 20) begin
      n++;
      tick();
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL timeout_req_cycles got=%0d required 8", n);
    end
    total++;
    if ({done_o, err_code_o, busy_o} !== {1'b1, 2'd2, 1'b0}) begin
      bad++;
      $display("FAIL timeout_done done=%b err=%0d busy=%b required 1 2 0", done_o, err_code_o, busy_o);
    end
    tick();
    rvalid_i = 1'b1;
    rdata_i = 32'h9999_9999;
    tick();
    rvalid_i = 1'b0;
    total++;
    if ({done_o, busy_o, err_code_o, rdata_o} !== {1'b0, 1'b0, 2'd2, 32'h0BAD_CAFE}) begin
      bad++;
      $display("FAIL timeout_late_rvalid done=%b busy=%b err=%0d rdata=%h required 0 0 2 0badcafe",
               done_o, busy_o, err_code_o, rdata_o);
    end
    tick();
  endtask

  task automatic test_illegal;
    logic saw_req;
    sb.push_back('{err: 2'd3, rdata: 32'h0BAD_CAFE});
    start_read_i = 1'b1;
    start_write_i = 1'b1;
    addr_i = 32'h0000_6000;
    tick();
    start_read_i = 1'b0;
    start_write_i = 1'b0;
    total++;
    if ({done_o, err_code_o, req_o, busy_o} !== {1'b1, 2'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL illegal_both done=%b err=%0d req=%b busy=%b required 1 3 0 0",
               done_o, err_code_o, req_o, busy_o);
    end
    tick();
    sb.push_back('{err: 2'd3, rdata: 32'h0BAD_CAFE});
    start_read_i = 1'b1;
    addr_i = 32'h0000_1002;
    tick();
    start_read_i = 1'b0;
    total++;
    if ({done_o, err_code_o} !== {1'b1, 2'd3}) begin
      bad++;
      $display("FAIL illegal_misaligned done=%b err=%0d required 1 3", done_o, err_code_o);
    end
    saw_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      saw_req = saw_req | req_o | busy_o;
      tick();
    end
    total++;
    if (saw_req !== 1'b0) begin
      bad++;
      $display("FAIL illegal_no_req saw_req=%b required 0", saw_req);
    end
  endtask

  task automatic test_reset_mid;
    start_read_i = 1'b1;
    addr_i = 32'h0000_7000;
    tick();
    start_read_i = 1'b0;
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({req_o, we_o, be_o, addr_o, wdata_o, rdata_o, done_o, busy_o, err_code_o} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs req=%b be=%h addr=%h rd=%h done=%b busy=%b err=%0d required all zero",
               req_o, be_o, addr_o, rdata_o, done_o, busy_o, err_code_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    rvalid_i = 1'b1;
    rdata_i = 32'h5555_5555;
    tick();
    rvalid_i = 1'b0;
    total++;
    if ({done_o, busy_o, rdata_o} !== {1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_mid_late_rvalid done=%b busy=%b rdata=%h required 0 0 00000000",
               done_o, busy_o, rdata_o);
    end
    sb.push_back('{err: 2'd0, rdata: 32'hCAFE_F00D});
    start_read_i = 1'b1;
    addr_i = 32'h0000_8000;
    tick();
    start_read_i = 1'b0;
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    rvalid_i = 1'b1;
    rdata_i = 32'hCAFE_F00D;
    tick();
    rvalid_i = 1'b0;
    total++;
    if ({done_o, err_code_o, rdata_o} !== {1'b1, 2'd0, 32'hCAFE_F00D}) begin
      bad++;
      $display("FAIL reset_mid_recover done=%b err=%0d rdata=%h required 1 0 cafef00d",
               done_o, err_code_o, rdata_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_bus_err();
    test_limit();
    test_timeout();
    test_illegal();
    test_reset_mid();
    tick();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drained pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
